ioctl_upload_server: RTL and testbench
======================================

Name: ioctl_upload_server

Overview:
- Responder for the HPS ioctl upload (read-back) direction, the counterpart of the ROM download path into the core.
- Serves save data byte by byte to the HPS when an upload is requested: high-score table, NVRAM, DIP snapshot.
- Requests a core pause before any access, then fetches each requested byte from a synchronous core RAM port.
- Holds off the HPS with ioctl_wait until each byte is valid.

Parameters:
- AW, 16: width of the core RAM byte address.
- BASE, 0: RAM address that maps to upload offset 0.
- LEN, 256: number of bytes served. Offsets >= LEN return PAD.
- RAM_LAT, 2: core RAM read latency in clk_sys cycles. Legal range 1..7.
- PAD, 8'hFF: value returned for out-of-range offsets.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  level from hps_io; high for the whole upload session.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte offset of the current read.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  high means the HPS must not sample ioctl_din or issue ioctl_rd.
- pause_req  out  1  asks the core to halt the CPU and release the RAM port.
- pause_ack  in  1  core confirms it is halted.
- ram_addr  out  AW  core RAM read address.
- ram_rd  out  1  one-cycle read strobe to core RAM.
- ram_q  in  8  core RAM data, valid RAM_LAT cycles after ram_rd.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a session ends.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; latency counter 0; upload edge-detect register 0.
- All outputs are registered.
- IDLE:
  - A rising edge of ioctl_upload (registered edge detect) moves to PAUSE and sets pause_req=1, ioctl_wait=1, busy=1.
  - ioctl_rd is ignored in IDLE.
- PAUSE:
  - Holds ioctl_wait=1.
  - On pause_ack=1, moves to READY and clears ioctl_wait on the same edge.
  - There is no timeout.
- READY, on ioctl_rd=1:
  - If ioctl_addr < LEN (full 25-bit unsigned compare): ram_addr <= BASE + ioctl_addr[AW-1:0], truncated modulo 2^AW. Also ram_rd <= 1 for one cycle, ioctl_wait <= 1, counter <= RAM_LAT, and the state moves to FETCH.
  - Otherwise: ioctl_din <= PAD, ioctl_wait stays 0, and the state stays READY.
- FETCH:
  - The counter decrements every edge.
  - On the edge where the counter equals 1, ram_q is sampled into ioctl_din, ioctl_wait <= 0, and the state returns to READY.
  - Timing: ioctl_rd sampled at edge T gives ram_rd high after T, ram_q sampled at edge T+RAM_LAT, and ioctl_din valid with wait low after that same edge.
  - ioctl_rd in FETCH is a protocol violation. It is ignored and does not queue.
- End of session: ioctl_upload low in PAUSE, READY or FETCH, taking priority over all other events in that cycle, does the following:
  - state returns to IDLE;
  - pause_req, ioctl_wait and ram_rd clear;
  - busy clears;
  - done pulses for one cycle.
  - An in-flight fetch is abandoned and ioctl_din keeps its last value.
- Pause acknowledge: pause_ack dropping in READY or FETCH does not abort the session. pause_req stays high until the session ends.
- Simultaneous events: an ioctl_upload rising edge and ioctl_rd in the same cycle means the read is ignored.
- Back-to-back reads: the earliest accepted next ioctl_rd is in the first cycle after ioctl_wait falls.
- Reset mid-operation: every output is cleared immediately, with no done pulse.

Test Plan:
- Basic fetch: reset, then raise ioctl_upload and assert pause_ack 3 cycles later.
  - pause_req rises 1 cycle after the upload edge; ioctl_wait is high until the edge after pause_ack; busy=1.
  - RAM preloaded with byte[i]=i^8'h5A and RAM_LAT=2: ioctl_rd at offset 0x10 gives ram_addr=0x0010 and ram_rd pulsed; ioctl_din=0x4A and ioctl_wait low exactly 2 cycles after ram_rd.
- Stream with BASE offset: BASE=0x0800, 256 consecutive reads issued each on the cycle after wait falls.
  - Every ram_addr equals 0x0800+i and every byte matches.
  - No read is lost and ram_rd never pulses twice per strobe.
- Out-of-range read: ioctl_rd at offset 256 (LEN=256) and at 0x1000000.
  - ioctl_din=0xFF one cycle later, ioctl_wait never rises, ram_rd stays 0.
- End of session during FETCH: drop ioctl_upload in the cycle after ram_rd.
  - Next edge: state IDLE, ioctl_wait=0, pause_req=0, busy=0, done high for exactly one cycle, ioctl_din unchanged.
- Protocol violations: ioctl_rd pulsed during FETCH and in the same cycle as the upload rising edge.
  - Both are ignored: exactly one ram_rd for the legal strobe, no extra ram_rd.
  - With RAM_LAT=1, wait falls 1 cycle after ram_rd.
- Asynchronous reset: assert reset_n=0 mid-FETCH, between clock edges.
  - All outputs 0 immediately with no clock edge and no done pulse.
  - After release, a new upload session behaves as in the basic fetch scenario.

Source files
------------

// File: rtl/ioctl_upload_server.sv
// ============================================================================
// ioctl_upload_server
// Serves core save data (hiscore/NVRAM/DIP) to the HPS during an ioctl upload.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ioctl_upload_server #(
   parameter int          AW      = 16,
   parameter int          BASE    = 0,
   parameter int          LEN     = 256,
   parameter int          RAM_LAT = 2,
   parameter logic [7:0]  PAD     = 8'hFF
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_upload,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          pause_req,
   input  logic          pause_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [7:0]    ram_q,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PAUSE = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [1:0] S_FETCH = 2'd3;

   localparam logic [2:0]    C_LAT  = 3'(RAM_LAT);
   localparam logic [25:0]   C_LEN  = 26'(LEN);
   localparam logic [AW-1:0] C_BASE = AW'(BASE);

   logic [1:0]    r_state, w_state_nxt;
   logic          r_upload_d;
   logic [2:0]    r_cnt, w_cnt_nxt;
   logic [7:0]    w_din_nxt;
   logic          w_wait_nxt, w_preq_nxt, w_rrd_nxt, w_done_nxt;
   logic [AW-1:0] w_raddr_nxt;
   logic          w_rise, w_in_range;

   assign w_rise     = ioctl_upload & ~r_upload_d;
   assign w_in_range = {1'b0, ioctl_addr} < C_LEN;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_upload_d <= 1'b0;
         r_cnt      <= 3'd0;
         ioctl_din  <= 8'd0;
         ioctl_wait <= 1'b0;
         pause_req  <= 1'b0;
         ram_addr   <= '0;
         ram_rd     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_upload_d <= ioctl_upload;
         r_cnt      <= w_cnt_nxt;
         ioctl_din  <= w_din_nxt;
         ioctl_wait <= w_wait_nxt;
         pause_req  <= w_preq_nxt;
         ram_addr   <= w_raddr_nxt;
         ram_rd     <= w_rrd_nxt;
         busy       <= (w_state_nxt != S_IDLE);
         done       <= w_done_nxt;
      end
   end

   // Upload going low outranks every other event once a session is open.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise) w_state_nxt = S_PAUSE;
         S_PAUSE: if (!ioctl_upload) w_state_nxt = S_IDLE;
                  else if (pause_ack) w_state_nxt = S_READY;
         S_READY: if (!ioctl_upload) w_state_nxt = S_IDLE;
                  else if (ioctl_rd && w_in_range) w_state_nxt = S_FETCH;
         S_FETCH: if (!ioctl_upload) w_state_nxt = S_IDLE;
                  else if (r_cnt == 3'd1) w_state_nxt = S_READY;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_din_nxt   = ioctl_din;
      w_wait_nxt  = ioctl_wait;
      w_preq_nxt  = pause_req;
      w_raddr_nxt = ram_addr;
      w_rrd_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      if (r_state == S_IDLE) begin
         if (w_rise) begin
            w_preq_nxt = 1'b1;
            w_wait_nxt = 1'b1;
         end
      end else if (!ioctl_upload) begin
         w_preq_nxt = 1'b0;
         w_wait_nxt = 1'b0;
         w_done_nxt = 1'b1;
         w_cnt_nxt  = 3'd0;
      end else begin
         case (r_state)
            S_PAUSE: if (pause_ack) w_wait_nxt = 1'b0;
            S_READY: begin
               if (ioctl_rd) begin
                  if (w_in_range) begin
                     w_raddr_nxt = C_BASE + ioctl_addr[AW-1:0];
                     w_rrd_nxt   = 1'b1;
                     w_wait_nxt  = 1'b1;
                     w_cnt_nxt   = C_LAT;
                  end else begin
                     w_din_nxt = PAD;
                  end
               end
            end
            S_FETCH: begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  w_din_nxt  = ram_q;
                  w_wait_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ioctl_upload_server.sv
// ============================================================================
// tb_ioctl_upload_server
// Directed bench: instance A (BASE=0, RAM_LAT=2), instance B (BASE=0x0800, RAM_LAT=1).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ioctl_upload_server;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;

   logic        a_upload, a_rd, a_ack, a_wait, a_preq, a_rrd, a_busy, a_done;
   logic [24:0] a_addr;
   logic [7:0]  a_din, a_q;
   logic [15:0] a_raddr;

   logic        b_upload, b_rd, b_ack, b_wait, b_preq, b_rrd, b_busy, b_done;
   logic [24:0] b_addr;
   logic [7:0]  b_din, b_q;
   logic [15:0] b_raddr;

   int n_cmp = 0, n_err = 0;
   int a_rrd_cnt = 0, a_done_cnt = 0, b_rrd_cnt = 0;

   ioctl_upload_server #(.AW(16), .BASE(0), .LEN(256), .RAM_LAT(2), .PAD(8'hFF)) dut_a (
      .clk_sys(clk), .reset_n(rst_n), .ioctl_upload(a_upload), .ioctl_rd(a_rd),
      .ioctl_addr(a_addr), .ioctl_din(a_din), .ioctl_wait(a_wait), .pause_req(a_preq),
      .pause_ack(a_ack), .ram_addr(a_raddr), .ram_rd(a_rrd), .ram_q(a_q),
      .busy(a_busy), .done(a_done));

   ioctl_upload_server #(.AW(16), .BASE(16'h0800), .LEN(256), .RAM_LAT(1), .PAD(8'hFF)) dut_b (
      .clk_sys(clk), .reset_n(rst_n), .ioctl_upload(b_upload), .ioctl_rd(b_rd),
      .ioctl_addr(b_addr), .ioctl_din(b_din), .ioctl_wait(b_wait), .pause_req(b_preq),
      .pause_ack(b_ack), .ram_addr(b_raddr), .ram_rd(b_rrd), .ram_q(b_q),
      .busy(b_busy), .done(b_done));

   function automatic logic [7:0] ram_byte(input logic [15:0] ad);
      return ad[7:0] ^ ad[15:8] ^ 8'h5A;
   endfunction

   // RAM models: data is only valid in the cycle the DUT should sample it.
   logic        a_pipe_rd = 1'b0;
   logic [15:0] a_pipe_addr = 16'd0;
   always @(posedge clk) begin
      a_pipe_rd   <= a_rrd;
      a_pipe_addr <= a_raddr;
   end
   assign a_q = a_pipe_rd ? ram_byte(a_pipe_addr) : 8'hEE;
   assign b_q = b_rrd ? ram_byte(b_raddr) : 8'hEE;

   always @(negedge clk) begin
      if (a_rrd === 1'b1) a_rrd_cnt++;
      if (a_done === 1'b1) a_done_cnt++;
      if (b_rrd === 1'b1) b_rrd_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic a_start;
      a_upload = 1'b1;
      tick;
      chk("a_preq_rise", 32'(a_preq), 1);
      chk("a_wait_rise", 32'(a_wait), 1);
      chk("a_busy_rise", 32'(a_busy), 1);
      tick;
      chk("a_wait_pause1", 32'(a_wait), 1);
      tick;
      a_ack = 1'b1;
      chk("a_wait_pause2", 32'(a_wait), 1);
      tick;
      chk("a_wait_ready", 32'(a_wait), 0);
      chk("a_preq_ready", 32'(a_preq), 1);
      chk("a_busy_ready", 32'(a_busy), 1);
   endtask

   task automatic a_read(input logic [24:0] off, input logic [15:0] exp_addr);
      int c0;
      c0 = a_rrd_cnt;
      a_rd = 1'b1;
      a_addr = off;
      tick;
      a_rd = 1'b0;
      chk("a_ram_addr", 32'(a_raddr), 32'(exp_addr));
      chk("a_ram_rd", 32'(a_rrd), 1);
      chk("a_wait_fetch", 32'(a_wait), 1);
      tick;
      chk("a_ram_rd_pulse", 32'(a_rrd), 0);
      chk("a_wait_fetch2", 32'(a_wait), 1);
      tick;
      chk("a_din", 32'(a_din), 32'(ram_byte(exp_addr)));
      chk("a_wait_done", 32'(a_wait), 0);
      chk("a_ram_rd_count", a_rrd_cnt - c0, 1);
   endtask

   task automatic a_oor(input logic [24:0] off);
      int c0;
      c0 = a_rrd_cnt;
      a_rd = 1'b1;
      a_addr = off;
      tick;
      a_rd = 1'b0;
      chk("a_oor_din", 32'(a_din), 'hFF);
      chk("a_oor_wait", 32'(a_wait), 0);
      chk("a_oor_rrd", 32'(a_rrd), 0);
      tick;
      chk("a_oor_wait2", 32'(a_wait), 0);
      chk("a_oor_rrd_count", a_rrd_cnt - c0, 0);
   endtask

   initial begin
      int c0;
      a_upload = 0; a_rd = 0; a_ack = 0; a_addr = '0;
      b_upload = 0; b_rd = 0; b_ack = 0; b_addr = '0;
      #12;
      chk("rst_a_din",   32'(a_din), 0);
      chk("rst_a_wait",  32'(a_wait), 0);
      chk("rst_a_preq",  32'(a_preq), 0);
      chk("rst_a_raddr", 32'(a_raddr), 0);
      chk("rst_a_rrd",   32'(a_rrd), 0);
      chk("rst_a_busy",  32'(a_busy), 0);
      chk("rst_a_done",  32'(a_done), 0);
      chk("rst_b_busy",  32'(b_busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick;

      // Basic session and fetch at offset 0x10
      a_start;
      a_read(25'h10, 16'h0010);
      chk("a_din_basic", 32'(a_din), 'h4A);

      // Dropping pause_ack mid-session keeps the session alive
      a_ack = 1'b0;
      tick;
      chk("a_ackdrop_preq", 32'(a_preq), 1);
      chk("a_ackdrop_busy", 32'(a_busy), 1);
      a_read(25'h20, 16'h0020);

      // Out-of-range offsets around in-range ones
      a_oor(25'd256);
      a_read(25'hFF, 16'h00FF);
      chk("a_din_last", 32'(a_din), 'hA5);
      a_oor(25'h1000000);

      // End of session while a fetch is in flight
      a_read(25'h30, 16'h0030);
      c0 = a_done_cnt;
      a_rd = 1'b1;
      a_addr = 25'h40;
      tick;
      a_rd = 1'b0;
      chk("a_eos_rrd", 32'(a_rrd), 1);
      a_upload = 1'b0;
      tick;
      chk("a_eos_wait", 32'(a_wait), 0);
      chk("a_eos_preq", 32'(a_preq), 0);
      chk("a_eos_busy", 32'(a_busy), 0);
      chk("a_eos_done", 32'(a_done), 1);
      chk("a_eos_din",  32'(a_din), 'h6A);
      a_ack = 1'b0;
      tick;
      chk("a_eos_done_clr", 32'(a_done), 0);
      chk("a_eos_din_keep", 32'(a_din), 'h6A);
      chk("a_eos_done_cnt", a_done_cnt - c0, 1);

      // Asynchronous reset in the middle of a fetch
      a_start;
      a_rd = 1'b1;
      a_addr = 25'h50;
      tick;
      a_rd = 1'b0;
      chk("a_ar_rrd", 32'(a_rrd), 1);
      c0 = a_done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("a_ar_din",   32'(a_din), 0);
      chk("a_ar_wait",  32'(a_wait), 0);
      chk("a_ar_preq",  32'(a_preq), 0);
      chk("a_ar_raddr", 32'(a_raddr), 0);
      chk("a_ar_rrd0",  32'(a_rrd), 0);
      chk("a_ar_busy",  32'(a_busy), 0);
      chk("a_ar_done",  32'(a_done), 0);
      a_upload = 1'b0;
      a_ack = 1'b0;
      tick;
      tick;
      chk("a_ar_no_done", a_done_cnt - c0, 0);
      rst_n = 1'b1;
      tick;
      a_start;
      a_read(25'h10, 16'h0010);
      chk("a_ar_din_basic", 32'(a_din), 'h4A);
      a_upload = 1'b0;
      tick;
      chk("a_end_done", 32'(a_done), 1);
      chk("a_end_busy", 32'(a_busy), 0);
      a_ack = 1'b0;
      tick;

      // Instance B: read on the upload edge is ignored
      b_upload = 1'b1;
      b_rd = 1'b1;
      b_addr = 25'h5;
      tick;
      b_rd = 1'b0;
      chk("b_edge_preq", 32'(b_preq), 1);
      chk("b_edge_wait", 32'(b_wait), 1);
      chk("b_edge_rrd",  32'(b_rrd), 0);
      b_ack = 1'b1;
      tick;
      chk("b_ready_wait", 32'(b_wait), 0);
      chk("b_ready_rrd",  32'(b_rrd), 0);

      // Full stream, back-to-back, with strobes injected during FETCH
      c0 = b_rrd_cnt;
      for (int i = 0; i < 256; i++) begin
         b_rd = 1'b1;
         b_addr = 25'(i);
         tick;
         b_rd = 1'b0;
         chk("b_stream_addr", 32'(b_raddr), 32'(16'(16'h0800 + i)));
         chk("b_stream_rrd",  32'(b_rrd), 1);
         chk("b_stream_wait", 32'(b_wait), 1);
         if (i == 3 || i == 200) begin
            b_rd = 1'b1;
            b_addr = 25'h7;
         end
         tick;
         b_rd = 1'b0;
         chk("b_stream_din",  32'(b_din), 32'(ram_byte(16'(16'h0800 + i))));
         chk("b_stream_wait0", 32'(b_wait), 0);
         chk("b_stream_rrd0", 32'(b_rrd), 0);
      end
      tick;
      chk("b_stream_rrd_count", b_rrd_cnt - c0, 256);
      b_upload = 1'b0;
      tick;
      chk("b_end_done", 32'(b_done), 1);
      chk("b_end_busy", 32'(b_busy), 0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
